// File: rtl/core_defs.sv
// Shared definitions for the pipeline sequencer: FSM states, vector selection
// and the default word addresses of the reset and interrupt vectors.
package core_defs;

  typedef enum logic [2:0] {
    S_VA,
    S_VB,
    S_VC,
    S_RUN,
    S_HALT
  } state_t;

  typedef enum logic {
    VEC_RST,
    VEC_INT
  } vec_sel_t;

  localparam int unsigned RST_VEC_ADDR = 0;
  localparam int unsigned INT_VEC_ADDR = 2;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register the ID
// instruction is about to read.
module hazard_detect #(
  parameter int unsigned RA_W = 3
) (
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  output logic            hazard
);

  // Stall request when either used source matches the pending load target.
  always_comb begin
    hazard = ex_mem_read &
             ((id_uses_rs & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: vector fetch after reset and interrupt, load-use stalls,
// HLT halting and interrupt entry.
module pipeline_sequencer
  import core_defs::*;
#(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RA_W         = 3,
  parameter int unsigned RST_VEC_ADDR = core_defs::RST_VEC_ADDR,
  parameter int unsigned INT_VEC_ADDR = core_defs::INT_VEC_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_mem_read,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_hlt,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              intr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  output logic              pc_write,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_vec,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              save_epc,
  output logic [PC_W-1:0]   epc_val,
  output logic              halted,
  output logic              busy
);

  state_t            state, next_state;
  vec_sel_t          vec_sel, next_vec_sel;
  logic              int_pend;
  logic              halted_q;
  logic [DATA_W-1:0] vec_lo, vec_hi;
  logic [PC_W-1:0]   base;
  logic              hazard;

  hazard_detect #(
    .RA_W(RA_W)
  ) u_hazard (
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .hazard     (hazard)
  );

  assign base = (vec_sel == VEC_INT) ? PC_W'(INT_VEC_ADDR) : PC_W'(RST_VEC_ADDR);

  // State, vector registers, pending interrupt and registered halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_VA;
      vec_sel  <= VEC_RST;
      int_pend <= 1'b0;
      vec_lo   <= '0;
      vec_hi   <= '0;
      halted_q <= 1'b0;
    end else begin
      state    <= next_state;
      vec_sel  <= next_vec_sel;
      // Clear wins over a simultaneous new request.
      int_pend <= save_epc ? 1'b0 : (int_pend | intr);
      if (state == S_VB) vec_lo <= mem_rdata;
      if (state == S_VC) vec_hi <= mem_rdata;
      halted_q <= (next_state == S_HALT);
    end
  end

  // Next-state and strobe decode; reset forces flushes high and all else low.
  always_comb begin
    next_state   = state;
    next_vec_sel = vec_sel;
    mem_req      = 1'b0;
    mem_addr     = '0;
    pc_write     = 1'b0;
    pc_load      = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    save_epc     = 1'b0;
    busy         = 1'b0;
    halted       = halted_q;
    // Hi word is still on mem_rdata in S_VC, so the vector is presented unregistered there.
    pc_vec       = (state == S_VC) ? {mem_rdata, vec_lo} : {vec_hi, vec_lo};
    unique case (state)
      S_VA: begin
        mem_req    = 1'b1;
        mem_addr   = base;
        busy       = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        next_state = S_VB;
      end
      S_VB: begin
        mem_req    = 1'b1;
        mem_addr   = base + PC_W'(1);
        busy       = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        next_state = S_VC;
      end
      S_VC: begin
        pc_load    = 1'b1;
        busy       = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        next_state = S_RUN;
      end
      S_RUN: begin
        if (hazard) begin
          idex_flush = 1'b1;
        end else if (int_pend) begin
          save_epc     = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          next_vec_sel = VEC_INT;
          next_state   = S_VA;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          if (id_is_hlt) next_state = S_HALT;
        end
      end
      S_HALT: begin
        idex_flush = 1'b1;
        if (int_pend) begin
          save_epc     = 1'b1;
          ifid_flush   = 1'b1;
          next_vec_sel = VEC_INT;
          next_state   = S_VA;
        end
      end
      default: next_state = S_VA;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      mem_addr   = '0;
      pc_write   = 1'b0;
      pc_load    = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      save_epc   = 1'b0;
      busy       = 1'b0;
      halted     = 1'b0;
      pc_vec     = '0;
    end
    epc_val = save_epc ? id_pc : '0;
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus random
// traffic, compared each cycle against a behavioural model of the sequencer.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_read;
  logic [2:0]  ex_rd, id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt, id_is_hlt;
  logic [31:0] id_pc;
  logic        intr;
  logic [15:0] mem_rdata;
  logic        mem_req, pc_write, pc_load, ifid_write, ifid_flush, idex_flush;
  logic        save_epc, halted, busy;
  logic [31:0] mem_addr, pc_vec, epc_val;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: fetch step (0 = not fetching, 1..3 = word-request/word-request/load),
  // halted flag, pending interrupt, vector source and last fetched vector.
  int          m_step;
  bit          m_halted, m_pend, m_int;
  logic [31:0] m_pc_vec;
  logic [15:0] vmem [4];

  pipeline_sequencer #(
    .PC_W(32), .DATA_W(16), .RA_W(3), .RST_VEC_ADDR(0), .INT_VEC_ADDR(2)
  ) dut (
    .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_hlt(id_is_hlt), .id_pc(id_pc), .intr(intr), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .pc_write(pc_write), .pc_load(pc_load),
    .pc_vec(pc_vec), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .save_epc(save_epc), .epc_val(epc_val),
    .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: supply memory data, check outputs at negedge, advance model.
  task automatic tick();
    int unsigned base;
    bit hz, e_req, e_pcw, e_load, e_ifw, e_iff, e_idf, e_save, e_halt, e_busy;
    logic [31:0] e_addr, e_vec;
    base = m_int ? 2 : 0;
    if (m_step == 2)      mem_rdata = vmem[base];
    else if (m_step == 3) mem_rdata = vmem[base+1];
    else                  mem_rdata = 16'($urandom);
    @(negedge clk);
    hz = ex_mem_read && ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    {e_req, e_pcw, e_load, e_ifw, e_iff, e_idf, e_save, e_halt, e_busy} = '0;
    e_addr = 0;
    e_vec  = m_pc_vec;
    if (reset) begin
      e_iff = 1; e_idf = 1; e_vec = 0;
    end else if (m_step != 0) begin
      e_busy = 1; e_iff = 1; e_idf = 1;
      e_req  = (m_step < 3);
      if (m_step == 1) e_addr = base;
      if (m_step == 2) e_addr = base + 1;
      if (m_step == 3) begin
        e_load = 1;
        e_vec  = {vmem[base+1], vmem[base]};
      end
    end else if (m_halted) begin
      e_halt = 1; e_idf = 1;
      if (m_pend) begin e_save = 1; e_iff = 1; end
    end else if (hz) begin
      e_idf = 1;
    end else if (m_pend) begin
      e_save = 1; e_iff = 1; e_idf = 1;
    end else begin
      e_pcw = 1; e_ifw = 1;
    end
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_addr", mem_addr, e_addr);
    chk("pc_write", 32'(pc_write), 32'(e_pcw));
    chk("pc_load", 32'(pc_load), 32'(e_load));
    chk("pc_vec", pc_vec, e_vec);
    chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
    chk("idex_flush", 32'(idex_flush), 32'(e_idf));
    chk("save_epc", 32'(save_epc), 32'(e_save));
    if (e_save) chk("epc_val", epc_val, id_pc);
    chk("halted", 32'(halted), 32'(e_halt));
    chk("busy", 32'(busy), 32'(e_busy));
    @(posedge clk);
    if (reset) begin
      m_step = 1; m_int = 0; m_pend = 0; m_pc_vec = 0; m_halted = 0;
    end else begin
      if (m_step == 3) begin
        m_pc_vec = e_vec; m_step = 0;
      end else if (m_step != 0) begin
        m_step++;
      end else if (e_save) begin
        m_step = 1; m_int = 1; m_halted = 0;
      end else if (!m_halted && !hz && id_is_hlt) begin
        m_halted = 1;
      end
      m_pend = e_save ? 1'b0 : (m_pend | intr);
    end
    #1;
  endtask

  task automatic rand_inputs(input int p_load, input int p_intr, input int p_hlt);
    ex_mem_read = ($urandom_range(99) < p_load);
    ex_rd       = 3'($urandom);
    id_rs       = 3'($urandom);
    id_rt       = 3'($urandom);
    id_uses_rs  = 1'($urandom);
    id_uses_rt  = 1'($urandom);
    intr        = ($urandom_range(99) < p_intr);
    id_is_hlt   = ($urandom_range(99) < p_hlt);
    id_pc       = $urandom;
  endtask

  task automatic quiet();
    ex_mem_read = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_hlt = 0; intr = 0;
    ex_rd = 0; id_rs = 0; id_rt = 0;
    id_pc = $urandom;
  endtask

  initial begin
    m_step = 1; m_halted = 0; m_pend = 0; m_int = 0; m_pc_vec = 0;
    vmem[0] = 16'h0010; vmem[1] = 16'h0000;
    vmem[2] = 16'($urandom); vmem[3] = 16'($urandom);
    quiet();
    mem_rdata = 0;
    reset = 1;
    #1;
    // Reset state.
    tick(); tick();
    reset = 0;
    // Reset vector fetch: addresses 0,1 then pc_load with 0x00000010.
    tick(); tick(); tick();
    chk("reset_vec", pc_vec, 32'h0000_0010);
    for (int i = 0; i < 5; i++) begin quiet(); tick(); end

    // Load-use stall on rs, then the same compare with rs unused.
    quiet(); ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
    tick();
    quiet(); tick();
    ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 0;
    tick();
    quiet(); ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1;
    tick();
    for (int i = 0; i < 40; i++) begin rand_inputs(50, 0, 0); tick(); end

    // HLT, hold for 100 cycles, wake on interrupt pulse.
    quiet(); id_is_hlt = 1; tick();
    for (int i = 0; i < 100; i++) begin rand_inputs(50, 0, 0); tick(); end
    quiet(); intr = 1; tick();
    quiet(); tick();
    for (int i = 0; i < 4; i++) begin quiet(); tick(); end

    // Hazard and interrupt together: stall first, entry next cycle.
    quiet(); ex_mem_read = 1; ex_rd = 2; id_rs = 2; id_uses_rs = 1; intr = 1;
    tick();
    quiet(); ex_mem_read = 1; ex_rd = 2; id_rs = 2; id_uses_rs = 1;
    tick();
    quiet(); tick();
    for (int i = 0; i < 4; i++) begin quiet(); tick(); end

    // HLT in ID while an interrupt is pending: interrupt wins.
    quiet(); intr = 1; tick();
    quiet(); id_is_hlt = 1; tick();
    for (int i = 0; i < 5; i++) begin quiet(); tick(); end
    chk("no_halt_after_int", 32'(halted), 32'(0));

    // Reset in the middle of an interrupt vector fetch.
    quiet(); intr = 1; tick();
    quiet(); tick();
    tick();
    reset = 1; tick();
    reset = 0;
    for (int i = 0; i < 4; i++) begin quiet(); tick(); end

    // Random mixed traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rand_inputs(40, 8, 8);
      reset = ($urandom_range(99) < 2);
      if (i % 97 == 0) begin vmem[2] = 16'($urandom); vmem[3] = 16'($urandom); end
      tick();
    end
    reset = 0;
    quiet();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
